// File: rtl/win_timer_pkg.sv
// Shared definitions for the win timer: state encoding and BCD digit constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package win_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2,
        SAT  = 2'd3
    } state_t;

    // True when a digit sits at its top value and the next increment would roll it over.
    function automatic logic is_max(input digit_t d);
        return d == DIGIT_MAX;
    endfunction

endpackage

// File: rtl/win_timer_bcd_digit.sv
// One BCD decade of the timer: increments on inc, zeroes on clr, rolls 9->0 with carry.
// Latency: value updates on the clock edge after inc/clr; carry is combinational.
// Backpressure: none; inc is accepted every cycle, clr takes priority over inc.
module bcd_digit
    import win_timer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    input  logic   clr,
    output digit_t value,
    output logic   carry
);

    // Carry ripples to the next decade in the same cycle as this digit wraps.
    assign carry = inc && is_max(value);

    // Digit register: clear wins, otherwise count 0..9 on inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= is_max(value) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/win_timer.sv
// Race/win stopwatch: 0.00..9.99 s BCD timer with start/stop/clear; optional best-time store (WIN_TIMER_BEST_EN).
// Latency: inputs sampled each rising edge, outputs change one cycle later; done is a registered 1-cycle pulse.
// Backpressure: none; level inputs, priority clear > stop > start, start/stop ignored once saturated.
module win_timer
    import win_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    output logic [3:0]   tmrs,
    output logic [3:0]   tmrms,
    output logic [3:0]   tmrmms,
    output logic         running,
    output logic         done
`ifdef WIN_TIMER_BEST_EN
    ,
    output logic [3:0]   best_s,
    output logic [3:0]   best_ms,
    output logic [3:0]   best_mms
`endif
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] psc, psc_nxt;
    logic          tick;
    logic          adv;
    logic          clr_dig;
    logic          done_nxt;
    logic          at_998;
    logic          c_mms, c_ms, c_s;
    logic          unused_carry;

    // The seconds decade never wraps because the timer saturates at 9.99.
    assign unused_carry = c_s;

    assign tick    = (state == RUN) && (psc == PSC_MAX);
    assign at_998  = is_max(tmrs) && is_max(tmrms) && (tmrmms == 4'd8);
    assign running = (state == RUN);

    // Next-state, prescaler and digit-advance decisions.
    always_comb begin
        state_nxt = state;
        psc_nxt   = psc;
        adv       = 1'b0;
        clr_dig   = 1'b0;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            psc_nxt   = '0;
            clr_dig   = 1'b1;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = RUN;
                RUN: begin
                    // The prescaler keeps counting through the stop cycle; a tick
                    // landing on stop is consumed but the digits stay frozen.
                    psc_nxt = tick ? '0 : psc + 1'b1;
                    if (stop) begin
                        state_nxt = HELD;
                        done_nxt  = 1'b1;
                    end else if (tick) begin
                        adv = 1'b1;
                        if (at_998) begin
                            state_nxt = SAT;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                HELD: if (start) state_nxt = RUN;
                SAT:  state_nxt = SAT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, prescaler and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            psc   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            psc   <= psc_nxt;
            done  <= done_nxt;
        end
    end

    bcd_digit u_mms (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (adv),
        .clr   (clr_dig),
        .value (tmrmms),
        .carry (c_mms)
    );

    bcd_digit u_ms (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (c_mms),
        .clr   (clr_dig),
        .value (tmrms),
        .carry (c_ms)
    );

    bcd_digit u_s (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (c_ms),
        .clr   (clr_dig),
        .value (tmrs),
        .carry (c_s)
    );

`ifdef WIN_TIMER_BEST_EN
    logic held_entry;
    logic new_best;

    // BCD digits compare correctly as one concatenated unsigned number.
    assign held_entry = (state == RUN) && (state_nxt == HELD);
    assign new_best   = {tmrs, tmrms, tmrmms} < {best_s, best_ms, best_mms};

    // Best-time store: only a stop can record a time; clear leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_s   <= DIGIT_MAX;
            best_ms  <= DIGIT_MAX;
            best_mms <= DIGIT_MAX;
        end else if (held_entry && new_best) begin
            best_s   <= tmrs;
            best_ms  <= tmrms;
            best_mms <= tmrmms;
        end
    end
`endif

endmodule

// File: tb/tb_win_timer.sv
// Bench for win_timer: two instances (TICK_DIV 4 and 2) share stimulus; a behavioural model feeds a scoreboard.
// Latency: expectations are pushed before each edge and popped shortly after it.
// Backpressure: none; the driver steps every cycle so model and DUTs stay in lockstep.
module tb_win_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;

    logic [3:0] s0, ms0, mms0, s1, ms1, mms1;
    logic       run0, done0, run1, done1;
`ifdef WIN_TIMER_BEST_EN
    logic [3:0] bs0, bms0, bmms0, bs1, bms1, bmms1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    win_timer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .tmrs(s0), .tmrms(ms0), .tmrmms(mms0), .running(run0), .done(done0)
`ifdef WIN_TIMER_BEST_EN
        , .best_s(bs0), .best_ms(bms0), .best_mms(bmms0)
`endif
    );

    win_timer #(.TICK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .tmrs(s1), .tmrms(ms1), .tmrmms(mms1), .running(run1), .done(done1)
`ifdef WIN_TIMER_BEST_EN
        , .best_s(bs1), .best_ms(bms1), .best_mms(bmms1)
`endif
    );

    // Behavioural model: elapsed time kept as an integer count of hundredths.
    localparam int M_IDLE = 0, M_RUN = 1, M_HELD = 2, M_SAT = 3;
    int m_mode[2];
    int m_part[2];
    int m_hund[2];
    int m_best[2];
    bit m_done[2];
    int div_of[2] = '{4, 2};

    typedef struct {
        logic [3:0]  s, ms, mms;
        logic        run, dn;
        logic [11:0] best;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];

    task automatic model_edge(input int i, input bit st, input bit sp, input bit cl, input bit rn);
        bit tk;
        m_done[i] = 1'b0;
        if (!rn) begin
            m_mode[i] = M_IDLE; m_part[i] = 0; m_hund[i] = 0; m_best[i] = 999;
        end else if (cl) begin
            m_mode[i] = M_IDLE; m_part[i] = 0; m_hund[i] = 0;
        end else if (m_mode[i] == M_IDLE || m_mode[i] == M_HELD) begin
            if (st) m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN) begin
            m_part[i] = (m_part[i] + 1) % div_of[i];
            tk = (m_part[i] == 0);
            if (sp) begin
                m_mode[i] = M_HELD;
                m_done[i] = 1'b1;
                if (m_hund[i] < m_best[i]) m_best[i] = m_hund[i];
            end else if (tk) begin
                m_hund[i] = m_hund[i] + 1;
                if (m_hund[i] == 999) begin
                    m_mode[i] = M_SAT;
                    m_done[i] = 1'b1;
                end
            end
        end
    endtask

    function automatic obs_t expect_of(input int i);
        obs_t e;
        e.s    = 4'(m_hund[i] / 100);
        e.ms   = 4'((m_hund[i] / 10) % 10);
        e.mms  = 4'(m_hund[i] % 10);
        e.run  = (m_mode[i] == M_RUN);
        e.dn   = m_done[i];
        e.best = {4'(m_best[i] / 100), 4'((m_best[i] / 10) % 10), 4'(m_best[i] % 10)};
        return e;
    endfunction

    task automatic push_both(input bit st, input bit sp, input bit cl, input bit rn);
        model_edge(0, st, sp, cl, rn);
        model_edge(1, st, sp, cl, rn);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    // One clock of stimulus: inputs change on the falling edge, expectation queued for the next rising edge.
    task automatic apply(input bit st, input bit sp, input bit cl, input bit rn);
        @(negedge clk);
        start = st; stop = sp; clear = cl; rst_n = rn;
        push_both(st, sp, cl, rn);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({s0, ms0, mms0, run0, done0, s1, ms1, mms1, run1, done1} !== '0) begin
            errors++;
            $display("FAIL %s: got %0d.%0d%0d run=%0b done=%0b / %0d.%0d%0d run=%0b done=%0b, want all zero",
                     name, s0, ms0, mms0, run0, done0, s1, ms1, mms1, run1, done1);
        end
    endtask

    // Idle until model instance i will hold target before the next edge (optionally with a tick due).
    task automatic run_until(input int i, input int target, input bit on_tick);
        int n;
        n = 0;
        while (!(m_hund[i] == target && (!on_tick || m_part[i] == div_of[i] - 1)) && n < 4000) begin
            idle(1);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL run_until: dut%0d reached %0d, want %0d within 4000 cycles", i, m_hund[i], target);
        end
    endtask

    task automatic cmp(input int i, input obs_t e, input logic [3:0] a_s, input logic [3:0] a_ms,
                       input logic [3:0] a_mms, input logic a_run, input logic a_dn, input logic [11:0] a_best);
        checks++;
        if ({a_s, a_ms, a_mms, a_run, a_dn} !== {e.s, e.ms, e.mms, e.run, e.dn}) begin
            errors++;
            $display("FAIL dut%0d t=%0t: got %0d.%0d%0d run=%0b done=%0b, want %0d.%0d%0d run=%0b done=%0b",
                     i, $time, a_s, a_ms, a_mms, a_run, a_dn, e.s, e.ms, e.mms, e.run, e.dn);
        end
`ifdef WIN_TIMER_BEST_EN
        checks++;
        if (a_best !== e.best) begin
            errors++;
            $display("FAIL dut%0d best t=%0t: got %h, want %h", i, $time, a_best, e.best);
        end
`else
        if (a_best !== 12'h000) $display("note: unexpected best value %h", a_best);
`endif
    endtask

    // Monitor: after each rising edge, pop the queued expectation for each instance and compare.
    initial begin
        obs_t e;
        logic [11:0] b0, b1;
        forever begin
            @(posedge clk);
            #2;
`ifdef WIN_TIMER_BEST_EN
            b0 = {bs0, bms0, bmms0};
            b1 = {bs1, bms1, bmms1};
`else
            b0 = 12'h000;
            b1 = 12'h000;
`endif
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, e, s0, ms0, mms0, run0, done0, b0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, e, s1, ms1, mms1, run1, done1, b1);
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized phase.
    initial begin
        for (int i = 0; i < 2; i++) model_edge(i, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        idle(2);

        // Start for one cycle, then 40 cycles of running.
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        idle(40);

        // Stop exactly on a tick at 0.37, then resume.
        run_until(0, 37, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);

        // All three controls together while running.
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Asynchronous reset mid-run at 0.05.
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(0, 5, 1'b0);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        push_both(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // Saturation: TICK_DIV=2 instance reaches 9.99 after 1998 cycles.
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1998);
        for (int k = 0; k < 6; k++) apply(k[0], ~k[0], 1'b0, 1'b1);
        idle(2100);
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        idle(4);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Best-time sequence: stops at 1.20, 0.85, 2.00 on the TICK_DIV=4 instance.
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(0, 120, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(0, 85, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        run_until(0, 200, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Randomized control activity.
        for (int k = 0; k < 1500; k++) begin
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 299) != 0);
        end
        idle(2);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/win_timer.md
WIN_TIMER -- requirements
Module: win_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk cycles per 0.01 s tick; legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  level-sampled; begin/resume timing.
REQ-005 SHALL have port stop  input  1  level-sampled; win reached, freeze time.
REQ-006 SHALL have port clear  input  1  level-sampled; zero time, return to IDLE.
REQ-007 SHALL have port tmrs  output  4  BCD seconds digit, 0-9.
REQ-008 SHALL have port tmrms  output  4  BCD tenths digit, 0-9.
REQ-009 SHALL have port tmrmms  output  4  BCD hundredths digit, 0-9.
REQ-010 SHALL have port running  output  1  high in RUN only.
REQ-011 SHALL have port done  output  1  one-cycle pulse on RUN->HELD or RUN->SAT.

Function
REQ-012 States SHALL be IDLE, RUN, HELD, SAT.
REQ-013 Transitions SHALL be: IDLE --start--> RUN; RUN --stop--> HELD; RUN --9.99 reached and tick--> SAT; HELD --start--> RUN (resume, digits kept); any state --clear--> IDLE.
REQ-014 Priority on simultaneous inputs SHALL be clear > stop > start.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; a tick SHALL fire in the cycle it equals TICK_DIV-1, after which it wraps to 0.
REQ-016 Prescaler SHALL reset to 0 on entry to IDLE; it SHALL hold its value in HELD so resume loses no partial tick.
REQ-017 On tick, tmrmms SHALL increment; 9->0 SHALL carry to tmrms; tmrms 9->0 SHALL carry to tmrs; all three updated in the same cycle.
REQ-018 A tick at 9.98 SHALL produce 9.99 and enter SAT in that same edge; digits SHALL never wrap to 0.00.
REQ-019 In SAT, start and stop SHALL be ignored; only clear SHALL leave SAT.
REQ-020 stop in the same cycle as a tick SHALL freeze the digits at their pre-tick value.
REQ-021 done SHALL be registered, asserted exactly one cycle after the transition edge, and never asserted on HELD->RUN.
REQ-022 Digits SHALL change only on tick or clear; latency from clear to 0.00 outputs SHALL be one cycle.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, prescaler 0, digits 0/0/0, running 0, done 0.
REQ-024 Reset mid-RUN SHALL discard the partial tick; after release, timing SHALL restart only on a new start.

Configuration
REQ-025 With WIN_TIMER_BEST_EN defined, the block SHALL add outputs best_s, best_ms, best_mms (4 bits each, reset 9/9/9) that update on RUN->HELD when the held time is strictly less than the stored best; clear SHALL NOT reset best; SAT SHALL never update best.
REQ-026 Without WIN_TIMER_BEST_EN, the best outputs and comparator SHALL be absent, with no other behaviour change.

Structure
REQ-027 A shared package SHALL hold the state encoding (2 bits, IDLE=0, RUN=1, HELD=2, SAT=3), the BCD digit width constant (4) and the max-digit constant (9).
REQ-028 The block SHALL instantiate three copies of a sub-module bcd_digit (inputs inc and clr; outputs value and carry, with carry asserted when inc is high and value is 9).

Verification
REQ-029 TICK_DIV=4: reset, start for 1 cycle -> running=1; after 40 clk cycles digits = 0/1/0.
REQ-030 TICK_DIV=4: run to 0.37, assert stop coincident with a tick -> digits hold 0/3/7, done pulses one cycle, running=0; start -> resumes and reaches 0/3/8 after 4 cycles.
REQ-031 TICK_DIV=2: run 1998 cycles -> 9/9/9, state SAT, one done pulse; further ticks, start and stop leave 9/9/9; clear -> 0/0/0 next cycle.
REQ-032 Assert start, stop and clear together in RUN -> IDLE, 0/0/0, no done pulse.
REQ-033 Drop rst_n mid-RUN at 0.05 asynchronously between edges -> outputs 0/0/0 before the next edge; after release, no counting until start.
REQ-034 WIN_TIMER_BEST_EN: stop at 1.20 then at 0.85 then at 2.00 -> best reads 9.99, then 1.20, then 0.85, then stays 0.85.
